// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR pseudo-random generator.
package lfsr_pkg;

  typedef enum logic {
    LFSR_GALOIS    = 1'b0,
    LFSR_FIBONACCI = 1'b1
  } lfsr_mode_e;

  localparam logic [31:0] LFSR_DEF_POLY32 = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEF_SEED   = 32'h0000_0001;

endpackage

// File: rtl/lfsr_step.sv
// Single-shift LFSR next-state function, Galois or Fibonacci form.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  lfsr_mode_e            mode,
  input  logic [DATA_WIDTH-1:0] poly,
  input  logic [DATA_WIDTH-1:0] state,
  output logic [DATA_WIDTH-1:0] next
);

  logic [DATA_WIDTH-2:0] taps;

  always_comb begin
    taps = poly[DATA_WIDTH-2:0] & {(DATA_WIDTH-1){state[0]}};
    next = state;
    if (mode == LFSR_GALOIS) begin
      // Galois: the bit shifted out wraps to the top and toggles tapped bits.
      next = {state[0], state[DATA_WIDTH-1:1] ^ taps};
    end else begin
      next = {^(state & poly), state[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_prng.sv
// Runtime-programmable LFSR PRNG with valid/ready output, STEP shifts per
// consumed word, and automatic all-zero lockup recovery with a sticky flag.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STEP       = 1,
  parameter logic [DATA_WIDTH-1:0] DEF_POLY   = DATA_WIDTH'(LFSR_DEF_POLY32),
  parameter logic [DATA_WIDTH-1:0] DEF_SEED   = DATA_WIDTH'(LFSR_DEF_SEED),
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic                  poly_wr_i,
  input  logic [DATA_WIDTH-1:0] poly_i,
  input  logic                  seed_wr_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  input  logic                  lockup_clr_i,
  output logic                  lockup_o
);

  if (DATA_WIDTH < 3) begin : g_bad_width
    $error("lfsr_prng: DATA_WIDTH must be at least 3");
  end
  if (STEP < 1 || STEP > DATA_WIDTH) begin : g_bad_step
    $error("lfsr_prng: STEP must be in 1..DATA_WIDTH");
  end
  if (DEF_SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: DEF_SEED must be nonzero");
  end

  logic [DATA_WIDTH-1:0] state_q;
  logic [DATA_WIDTH-1:0] poly_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  valid_q;
  logic                  lockup_q;

  logic [STEP:0][DATA_WIDTH-1:0] chain;
  lfsr_mode_e                    mode;
  logic                          advance;
  logic                          load;
  logic                          zero_hit;
  logic [DATA_WIDTH-1:0]         cand;
  logic [DATA_WIDTH-1:0]         state_d;
  logic [CNT_WIDTH-1:0]          cnt_d;

  assign mode     = lfsr_mode_e'(mode_i);
  assign chain[0] = state_q;

  for (genvar g = 0; g < STEP; g++) begin : g_chain
    lfsr_step #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
      .mode (mode),
      .poly (poly_q),
      .state(chain[g]),
      .next (chain[g+1])
    );
  end

  // A seed write consumes any coincident handshake but suppresses the advance.
  assign advance = valid_q & ready_i & ~seed_wr_i;

  always_comb begin
    cand  = state_q;
    cnt_d = cnt_q;
    load  = 1'b0;
    if (seed_wr_i) begin
      cand  = seed_i;
      cnt_d = '0;
      load  = 1'b1;
    end else if (advance) begin
      cand  = chain[STEP];
      cnt_d = cnt_q + CNT_WIDTH'(1);
      load  = 1'b1;
    end
    // Zero is absorbing in both forms, so only the chain end needs checking.
    zero_hit = load && (cand == '0);
    state_d  = zero_hit ? DEF_SEED : cand;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= DEF_SEED;
      poly_q   <= DEF_POLY;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= 1'b1;
      if (poly_wr_i) begin
        poly_q <= poly_i;
      end
      if (zero_hit) begin
        lockup_q <= 1'b1;
      end else if (lockup_clr_i) begin
        lockup_q <= 1'b0;
      end
    end
  end

  assign valid_o  = valid_q;
  assign dat_o    = state_q;
  assign cnt_o    = cnt_q;
  assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: 8-bit instances with STEP=1 and STEP=4.
module tb_lfsr_prng;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       poly_wr;
  logic [7:0] poly;
  logic       seed_wr;
  logic [7:0] seed;
  logic       ready;
  logic       lockup_clr;

  logic       valid1, valid4, lock1, lock4;
  logic [7:0] dat1, dat4;
  logic [31:0] cnt1, cnt4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lfsr_prng #(
    .DATA_WIDTH(8), .STEP(1), .DEF_POLY(8'hB8), .DEF_SEED(8'h01), .CNT_WIDTH(32)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .poly_wr_i(poly_wr), .poly_i(poly),
    .seed_wr_i(seed_wr), .seed_i(seed), .ready_i(ready), .valid_o(valid1),
    .dat_o(dat1), .cnt_o(cnt1), .lockup_clr_i(lockup_clr), .lockup_o(lock1)
  );

  lfsr_prng #(
    .DATA_WIDTH(8), .STEP(4), .DEF_POLY(8'hB8), .DEF_SEED(8'h01), .CNT_WIDTH(32)
  ) dut4 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .poly_wr_i(poly_wr), .poly_i(poly),
    .seed_wr_i(seed_wr), .seed_i(seed), .ready_i(ready), .valid_o(valid4),
    .dat_o(dat4), .cnt_o(cnt4), .lockup_clr_i(lockup_clr), .lockup_o(lock4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 1'b0; poly_wr = 1'b0; poly = 8'h00; seed_wr = 1'b0;
    seed = 8'h00; ready = 1'b0; lockup_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dat1 !== 8'h01 || valid1 !== 1'b0 || cnt1 !== 32'd0 || lock1 !== 1'b0)
      $display("FAIL reset_state: dat=%h valid=%b cnt=%0d lock=%b, want dat=01 valid=0 cnt=0 lock=0",
               dat1, valid1, cnt1, lock1);
    else passed++;
    tick();
    total++;
    if (valid1 !== 1'b1 || dat1 !== 8'h01)
      $display("FAIL valid_rise: valid=%b dat=%h, want valid=1 dat=01", valid1, dat1);
    else passed++;
  endtask

  task automatic test_galois();
    logic [7:0] exp_seq [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    bit zero_seen = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (dat1 !== exp_seq[i])
        $display("FAIL galois_seq[%0d]: dat=%h, want %h", i, dat1, exp_seq[i]);
      else passed++;
    end
    for (int i = 5; i < 255; i++) begin
      tick();
      if (dat1 === 8'h00) zero_seen = 1'b1;
    end
    ready = 1'b0;
    total++;
    if (dat1 !== 8'h01 || cnt1 !== 32'd255)
      $display("FAIL galois_period: dat=%h cnt=%0d, want dat=01 cnt=255", dat1, cnt1);
    else passed++;
    total++;
    if (zero_seen || lock1 !== 1'b0)
      $display("FAIL galois_nozero: zero_seen=%b lock=%b, want 0 0", zero_seen, lock1);
    else passed++;
  endtask

  task automatic test_step4();
    bit stable = 1'b1;
    do_reset();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (dat4 !== 8'h17 || cnt4 !== 32'd1)
      $display("FAIL step4_adv: dat=%h cnt=%0d, want dat=17 cnt=1", dat4, cnt4);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dat4 !== 8'h17 || cnt4 !== 32'd1 || valid4 !== 1'b1) stable = 1'b0;
    end
    total++;
    if (!stable)
      $display("FAIL step4_hold: dat=%h cnt=%0d valid=%b, want dat=17 cnt=1 valid=1",
               dat4, cnt4, valid4);
    else passed++;
  endtask

  task automatic test_fib_switch();
    logic [7:0] exp_seq [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
    do_reset();
    tick();
    mode = 1'b1; poly_wr = 1'b1; poly = 8'h03;
    tick();
    poly_wr = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (dat1 !== exp_seq[i])
        $display("FAIL fib_seq[%0d]: dat=%h, want %h", i, dat1, exp_seq[i]);
      else passed++;
    end
    mode = 1'b0;
    tick();
    total++;
    if (dat1 !== 8'h08)
      $display("FAIL mode_switch: dat=%h, want 08", dat1);
    else passed++;
    ready = 1'b0;
  endtask

  task automatic test_lockup();
    seed_wr = 1'b1; seed = 8'h00;
    tick();
    seed_wr = 1'b0;
    total++;
    if (dat1 !== 8'h01 || lock1 !== 1'b1 || cnt1 !== 32'd0)
      $display("FAIL lockup_seed0: dat=%h lock=%b cnt=%0d, want dat=01 lock=1 cnt=0",
               dat1, lock1, cnt1);
    else passed++;
    lockup_clr = 1'b1;
    tick();
    total++;
    if (lock1 !== 1'b0)
      $display("FAIL lockup_clr: lock=%b, want 0", lock1);
    else passed++;
    seed_wr = 1'b1; seed = 8'h00;
    tick();
    seed_wr = 1'b0; lockup_clr = 1'b0;
    total++;
    if (lock1 !== 1'b1)
      $display("FAIL lockup_set_wins: lock=%b, want 1", lock1);
    else passed++;
    lockup_clr = 1'b1;
    mode = 1'b1; poly_wr = 1'b1; poly = 8'h00; seed_wr = 1'b1; seed = 8'h01;
    tick();
    lockup_clr = 1'b0; poly_wr = 1'b0; seed_wr = 1'b0;
    total++;
    if (lock1 !== 1'b0 || dat1 !== 8'h01)
      $display("FAIL lockup_prep: lock=%b dat=%h, want lock=0 dat=01", lock1, dat1);
    else passed++;
    ready = 1'b1;
    repeat (8) tick();
    ready = 1'b0;
    total++;
    if (dat1 !== 8'h01 || lock1 !== 1'b1 || cnt1 !== 32'd8)
      $display("FAIL lockup_fib0: dat=%h lock=%b cnt=%0d, want dat=01 lock=1 cnt=8",
               dat1, lock1, cnt1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; poly_wr = 1'b1; poly = 8'hB8;
    tick();
    poly_wr = 1'b0;
    ready = 1'b1; seed_wr = 1'b1; seed = 8'h01;
    tick();
    seed_wr = 1'b0;
    total++;
    if (dat1 !== 8'h01 || cnt1 !== 32'd0)
      $display("FAIL seed_vs_hs: dat=%h cnt=%0d, want dat=01 cnt=0", dat1, cnt1);
    else passed++;
    poly_wr = 1'b1; poly = 8'h03;
    tick();
    poly_wr = 1'b0; ready = 1'b0;
    total++;
    if (dat1 !== 8'hB8 || cnt1 !== 32'd1)
      $display("FAIL poly_vs_hs: dat=%h cnt=%0d, want dat=B8 cnt=1", dat1, cnt1);
    else passed++;
    seed_wr = 1'b1; seed = 8'h01;
    tick();
    seed_wr = 1'b0; ready = 1'b1;
    tick();
    total++;
    if (dat1 !== 8'h83)
      $display("FAIL poly_new: dat=%h, want 83", dat1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    // Lockup is set first so the reset is seen to clear it.
    seed_wr = 1'b1; seed = 8'h00;
    tick();
    rst = 1'b1; seed_wr = 1'b1; seed = 8'hAA; poly_wr = 1'b1; poly = 8'h03;
    tick();
    rst = 1'b0; seed_wr = 1'b0; poly_wr = 1'b0;
    total++;
    if (dat1 !== 8'h01 || valid1 !== 1'b0 || cnt1 !== 32'd0 || lock1 !== 1'b0)
      $display("FAIL reset_mid: dat=%h valid=%b cnt=%0d lock=%b, want dat=01 valid=0 cnt=0 lock=0",
               dat1, valid1, cnt1, lock1);
    else passed++;
    tick();
    total++;
    if (valid1 !== 1'b1 || dat1 !== 8'h01)
      $display("FAIL reset_mid_valid: valid=%b dat=%h, want valid=1 dat=01", valid1, dat1);
    else passed++;
    tick();
    ready = 1'b0;
    total++;
    if (dat1 !== 8'hB8)
      $display("FAIL reset_mid_poly: dat=%h, want B8", dat1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_galois();
    test_step4();
    test_fib_switch();
    test_lockup();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
